sid_bus_sync: RTL and testbench

SID_BUS_SYNC -- requirements
Module: sid_bus_sync

---
 rtl/sid_bus_sync_if.sv | 53 +++++
 rtl/sid_bus_sync.sv | 212 +++++++++++++++++++++
 tb/tb_sid_bus_sync.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sid_bus_sync_if.sv
// Bus bundle for sid_bus_sync: raw asynchronous SID bus pins in, qualified
// clk-domain access strobes out.
interface sid_bus_sync_if;
  logic       phi2_in;
  logic       res_n_in;
  logic       cs_n_in;
  logic       rw_in;
  logic [4:0] addr_in;
  logic [7:0] data_in;

  logic [2:0] phase;
  logic [4:0] addr;
  logic [7:0] data;
  logic       cs;
  logic       oe;
  logic       we;
  logic       bus_res;
  logic       phi2_lost;

  modport master (
    output phi2_in,
    output res_n_in,
    output cs_n_in,
    output rw_in,
    output addr_in,
    output data_in,
    input  phase,
    input  addr,
    input  data,
    input  cs,
    input  oe,
    input  we,
    input  bus_res,
    input  phi2_lost
  );

  modport slave (
    input  phi2_in,
    input  res_n_in,
    input  cs_n_in,
    input  rw_in,
    input  addr_in,
    input  data_in,
    output phase,
    output addr,
    output data,
    output cs,
    output oe,
    output we,
    output bus_res,
    output phi2_lost
  );
endinterface

// File: rtl/sid_bus_sync.sv
// SID bus front end: synchronizes the raw CPU bus, filters PHI2, and turns each
// PHI2 high period into rise/commit/fall phase pulses with decoded qualifiers.
module sid_bus_sync #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned PHI2_FILTER  = 3,
  parameter int unsigned STROBE_DELAY = 8,
  parameter int unsigned LOST_TIMEOUT = 4095
) (
  input logic           clk,
  input logic           res,
  sid_bus_sync_if.slave bus
);

  localparam int unsigned SYNC_W = 17;
  localparam int unsigned FLT_W  = (PHI2_FILTER > 1) ? $clog2(PHI2_FILTER) : 1;
  localparam int unsigned DLY_W  = (STROBE_DELAY > 1) ? $clog2(STROBE_DELAY) : 1;
  localparam int unsigned WD_W   = $clog2(LOST_TIMEOUT + 1);

  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(PHI2_FILTER - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(STROBE_DELAY - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(LOST_TIMEOUT);

  localparam logic [1:0] ST_PHI1   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Reset is carried inverted so a cleared chain reads as "not in reset".
  logic [SYNC_W-1:0] w_raw;
  logic [SYNC_W-1:0] r_sync [SYNC_STAGES];
  logic [SYNC_W-1:0] w_sync;

  assign w_raw = {bus.phi2_in, ~bus.res_n_in, bus.cs_n_in, bus.rw_in, bus.addr_in, bus.data_in};

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  logic       w_phi2_s;
  logic       w_res_s;
  logic       w_cs_n_s;
  logic       w_rw_s;
  logic [4:0] w_addr_s;
  logic [7:0] w_data_s;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_phi2_s = w_sync[16];
  assign w_res_s  = w_sync[15];
  assign w_cs_n_s = w_sync[14];
  assign w_rw_s   = w_sync[13];
  assign w_addr_s = w_sync[12:8];
  assign w_data_s = w_sync[7:0];

  // PHI2 glitch filter: the count tracks consecutive samples that disagree
  // with the accepted level; the last one of the run flips the level.
  logic             r_phi2_f;
  logic [FLT_W-1:0] r_flt_cnt;
  logic             w_differ;
  logic             w_accept;
  logic             w_rise;
  logic             w_fall;

  assign w_differ = (w_phi2_s != r_phi2_f);
  assign w_accept = w_differ && (r_flt_cnt == FLT_LAST);
  assign w_rise   = w_accept && w_phi2_s;
  assign w_fall   = w_accept && !w_phi2_s;

  always_ff @(posedge clk) begin
    if (res) begin
      r_phi2_f  <= 1'b0;
      r_flt_cnt <= '0;
    end else if (!w_differ) begin
      r_flt_cnt <= '0;
    end else if (w_accept) begin
      r_phi2_f  <= w_phi2_s;
      r_flt_cnt <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + FLT_W'(1);
    end
  end

  logic [WD_W-1:0] r_wd;
  logic            w_lost;
  logic            r_bus_res;

  assign w_lost = (r_wd == WD_MAX);

  always_ff @(posedge clk) begin
    if (res) begin
      r_wd      <= '0;
      r_bus_res <= 1'b0;
    end else begin
      r_bus_res <= w_res_s;
      if (w_accept) begin
        r_wd <= '0;
      end else if (!w_lost) begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end

  logic [1:0]       r_state, w_state_d;
  logic [2:0]       r_phase, w_phase_d;
  logic [DLY_W-1:0] r_dly,   w_dly_d;
  logic             r_cs,    w_cs_d;
  logic             r_oe,    w_oe_d;
  logic             r_we,    w_we_d;
  logic [4:0]       r_addr,  w_addr_d;
  logic [7:0]       r_data,  w_data_d;

  always_comb begin
    w_state_d = r_state;
    w_phase_d = 3'b000;
    w_dly_d   = r_dly;
    w_cs_d    = r_cs;
    w_oe_d    = r_oe;
    w_we_d    = r_we;
    w_addr_d  = r_addr;
    w_data_d  = r_data;

    // A lost PHI2 parks the FSM, but the edge that ends the outage still counts.
    if (w_lost && !w_rise) begin
      w_state_d = ST_PHI1;
      w_cs_d    = 1'b0;
      w_oe_d    = 1'b0;
      w_we_d    = 1'b0;
    end else begin
      case (r_state)
        ST_PHI1: begin
          if (w_rise) begin
            w_state_d = ST_DELAY;
            w_phase_d = 3'b001;
            w_dly_d   = DLY_LOAD;
          end
        end
        ST_DELAY: begin
          if (w_fall) begin
            w_state_d = ST_PHI1;
            w_phase_d = 3'b100;
          end else if (r_dly == '0) begin
            w_state_d = ST_COMMIT;
            w_phase_d = 3'b010;
            w_addr_d  = w_addr_s;
            w_data_d  = w_data_s;
            w_cs_d    = !w_cs_n_s;
            w_oe_d    = !w_cs_n_s && w_rw_s;
            w_we_d    = !w_cs_n_s && !w_rw_s;
          end else begin
            w_dly_d = r_dly - DLY_W'(1);
          end
        end
        ST_COMMIT, ST_HOLD: begin
          if (w_fall) begin
            w_state_d = ST_PHI1;
            w_phase_d = 3'b100;
            w_cs_d    = 1'b0;
            w_oe_d    = 1'b0;
            w_we_d    = 1'b0;
          end else begin
            w_state_d = ST_HOLD;
          end
        end
        default: begin
          w_state_d = ST_PHI1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= ST_PHI1;
      r_phase <= 3'b000;
      r_dly   <= '0;
      r_cs    <= 1'b0;
      r_oe    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_dly   <= w_dly_d;
      r_cs    <= w_cs_d;
      r_oe    <= w_oe_d;
      r_we    <= w_we_d;
      r_addr  <= w_addr_d;
      r_data  <= w_data_d;
    end
  end

  assign bus.phase     = r_phase;
  assign bus.addr      = r_addr;
  assign bus.data      = r_data;
  assign bus.cs        = r_cs & ~w_lost;
  assign bus.oe        = r_oe & ~w_lost;
  assign bus.we        = r_we & ~w_lost & ~r_bus_res;
  assign bus.bus_res   = r_bus_res;
  assign bus.phi2_lost = w_lost;

  phase_onehot_a: assert property (@(posedge clk) disable iff (res) $onehot0(r_phase));

endmodule

// File: tb/tb_sid_bus_sync.sv
// Directed bench for sid_bus_sync: write/read/deselect cycles, PHI2 glitches,
// watchdog and reset behaviour, each timed against hand-derived tick counts.
module tb_sid_bus_sync;
  logic clk = 1'b0;
  logic res;

  always #5 clk = ~clk;

  sid_bus_sync_if bus_if ();

  sid_bus_sync #(
    .SYNC_STAGES (2),
    .PHI2_FILTER (3),
    .STROBE_DELAY(8),
    .LOST_TIMEOUT(4095)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int          at  [3];
  int          cnt [3];
  int          multi;
  logic [15:0] c_snap;
  logic [2:0]  h_snap;
  logic [2:0]  f_snap;
  logic        lost_at_rise;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raise PHI2 for hi ticks, observe total ticks, record pulse timing/snapshots.
  task automatic run_phi2(input int hi, input int total);
    for (int b = 0; b < 3; b++) begin
      at[b]  = 0;
      cnt[b] = 0;
    end
    multi        = 0;
    c_snap       = '0;
    h_snap       = '0;
    f_snap       = '1;
    lost_at_rise = 1'b1;
    bus_if.phi2_in = 1'b1;
    for (int t = 1; t <= total; t++) begin
      tick();
      if ($countones(bus_if.phase) > 1) multi++;
      for (int b = 0; b < 3; b++) begin
        if (bus_if.phase[b]) begin
          cnt[b]++;
          if (at[b] == 0) at[b] = t;
        end
      end
      if (bus_if.phase[0]) lost_at_rise = bus_if.phi2_lost;
      if (bus_if.phase[1]) c_snap = {bus_if.cs, bus_if.oe, bus_if.we, bus_if.addr, bus_if.data};
      if (at[1] != 0 && t == at[1] + 1) h_snap = {bus_if.cs, bus_if.oe, bus_if.we};
      if (bus_if.phase[2]) f_snap = {bus_if.cs, bus_if.oe, bus_if.we};
      if (t == hi) bus_if.phi2_in = 1'b0;
    end
  endtask

  initial begin
    int n;
    int pc;
    res              = 1'b1;
    bus_if.phi2_in   = 1'b0;
    bus_if.res_n_in  = 1'b1;
    bus_if.cs_n_in   = 1'b1;
    bus_if.rw_in     = 1'b1;
    bus_if.addr_in   = 5'h00;
    bus_if.data_in   = 8'h00;
    repeat (3) tick();
    chk("rst_phase", bus_if.phase, 3'b000);
    chk("rst_qual", {bus_if.cs, bus_if.oe, bus_if.we}, 3'b000);
    chk("rst_addr", bus_if.addr, 5'h00);
    chk("rst_data", bus_if.data, 8'h00);
    chk("rst_bus_res", bus_if.bus_res, 1'b0);
    chk("rst_lost", bus_if.phi2_lost, 1'b0);

    res = 1'b0;
    repeat (4) tick();
    chk("idle_bus_res", bus_if.bus_res, 1'b0);
    chk("idle_phase", bus_if.phase, 3'b000);

    // Write: rise after 2 sync + 3 filter ticks, commit 8 later, fall 5 after PHI2 drops.
    bus_if.cs_n_in = 1'b0;
    bus_if.rw_in   = 1'b0;
    bus_if.addr_in = 5'h18;
    bus_if.data_in = 8'h0F;
    run_phi2(12, 24);
    chk("wr_rise_at", at[0], 5);
    chk("wr_commit_at", at[1], 13);
    chk("wr_fall_at", at[2], 17);
    chk("wr_commit_cnt", cnt[1], 1);
    chk("wr_commit_snap", c_snap, {3'b101, 5'h18, 8'h0F});
    chk("wr_hold_qual", h_snap, 3'b101);
    chk("wr_fall_qual", f_snap, 3'b000);
    chk("wr_addr_hold", bus_if.addr, 5'h18);
    chk("wr_data_hold", bus_if.data, 8'h0F);
    chk("wr_onehot", multi, 0);

    bus_if.rw_in   = 1'b1;
    bus_if.addr_in = 5'h1B;
    bus_if.data_in = 8'hA5;
    run_phi2(12, 24);
    chk("rd_commit_at", at[1], 13);
    chk("rd_commit_snap", c_snap, {3'b110, 5'h1B, 8'hA5});
    chk("rd_hold_qual", h_snap, 3'b110);
    chk("rd_fall_qual", f_snap, 3'b000);

    bus_if.cs_n_in = 1'b1;
    bus_if.addr_in = 5'h04;
    bus_if.data_in = 8'h3C;
    run_phi2(12, 24);
    chk("nocs_commit_at", at[1], 13);
    chk("nocs_commit_snap", c_snap, {3'b000, 5'h04, 8'h3C});

    run_phi2(2, 12);
    chk("gl2_rise_cnt", cnt[0], 0);
    chk("gl2_commit_cnt", cnt[1], 0);
    chk("gl2_fall_cnt", cnt[2], 0);

    run_phi2(3, 14);
    chk("gl3_rise_at", at[0], 5);
    chk("gl3_fall_at", at[2], 8);
    chk("gl3_commit_cnt", cnt[1], 0);

    // Fall accepted at tick 8 of the previous run, 6 ticks before its end.
    n = 0;
    while (!bus_if.phi2_lost && n < 5000) begin
      tick();
      n++;
    end
    chk("wd_latency", n, 4089);
    chk("wd_lost", bus_if.phi2_lost, 1'b1);
    chk("wd_qual", {bus_if.cs, bus_if.oe, bus_if.we}, 3'b000);

    bus_if.cs_n_in = 1'b0;
    bus_if.rw_in   = 1'b0;
    bus_if.addr_in = 5'h18;
    bus_if.data_in = 8'h0F;
    run_phi2(12, 24);
    chk("wd_rise_at", at[0], 5);
    chk("wd_lost_at_rise", lost_at_rise, 1'b0);
    chk("wd_commit_at", at[1], 13);
    chk("wd_lost_after", bus_if.phi2_lost, 1'b0);

    // Reset while in HOLD with a write in flight.
    bus_if.phi2_in = 1'b1;
    repeat (14) tick();
    chk("pre_rst_we", bus_if.we, 1'b1);
    res            = 1'b1;
    bus_if.phi2_in = 1'b0;
    tick();
    chk("mid_rst_qual", {bus_if.cs, bus_if.oe, bus_if.we}, 3'b000);
    chk("mid_rst_phase", bus_if.phase, 3'b000);
    res = 1'b0;
    pc  = 0;
    repeat (10) begin
      tick();
      if (bus_if.phase != 3'b000) pc++;
    end
    chk("post_rst_phase", pc, 0);

    bus_if.res_n_in = 1'b0;
    tick();
    tick();
    chk("bus_res_2tick", bus_if.bus_res, 1'b0);
    tick();
    chk("bus_res_3tick", bus_if.bus_res, 1'b1);

    run_phi2(12, 24);
    chk("busres_commit_at", at[1], 13);
    chk("busres_commit_cnt", cnt[1], 1);
    chk("busres_commit_snap", c_snap, {3'b100, 5'h18, 8'h0F});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
